// File: rtl/serial_subtractor_pkg.sv
// Purpose : shared FSM encoding and default width for the bit-serial subtractor.
// Latency : n/a (type/constant definitions only).
// Backpressure: n/a.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Purpose : one-bit full subtractor, the per-bit datapath of serial_subtractor.
// Latency : combinational, zero cycles.
// Backpressure: none.
// Ports   : x (minuend bit), y (subtrahend bit), bin (borrow in),
//           d (difference bit), bout (borrow out).
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when x=0,y=1, or when x==y and a borrow is already pending.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Purpose : bit-serial unsigned subtractor computing diff = a - b - bin, LSB first.
// Latency : done pulses WIDTH+1 edges after the edge that samples start.
// Backpressure: start ignored while an operation runs; accepted again in the done cycle.
// Ports   : clk, rst (sync, active-high); start/a/b/bin request; busy, done,
//           diff, bout result; ovf (signed overflow) only when
//           SERIAL_SUBTRACTOR_OVF_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    import serial_subtractor_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             fs_d, fs_bout;
    logic             accept, last_bit;
    logic             busy_nxt, done_nxt;

    full_subtractor u_fs (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (br),
        .d    (fs_d),
        .bout (fs_bout)
    );

    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_bit = (state_q == RUN) && (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                busy_nxt = 1'b1;
                if (last_bit) state_d = DONE;
            end
            // A start seen here chains straight into the next operation.
            DONE: begin
                done_nxt = 1'b1;
                state_d  = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // busy/done are registered off the current state, so they trail the
    // state register by one cycle; diff/bout are already final when done rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            cnt     <= '0;
            br      <= 1'b0;
            a_sr    <= '0;
            b_sr    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy    <= busy_nxt;
            done    <= done_nxt;
            if (accept) begin
                a_sr <= a;
                b_sr <= b;
                br   <= bin;
                cnt  <= '0;
            end else if (state_q == RUN) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                br   <= fs_bout;
                cnt  <= cnt + CNT_W'(1);
                // Enter at the MSB so bit 0 lands at diff[0] after WIDTH shifts.
                diff <= {fs_d, diff[WIDTH-1:1]};
                if (last_bit) begin
                    bout <= fs_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    // Signed overflow: borrow into the sign bit differs from borrow out.
                    ovf  <= br ^ fs_bout;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           s_edge;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   done_total = 0;
    int   busy_cnt   = 0;
    logic prev_done  = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mbin, output logic [W-1:0] md,
                                  output logic mbo, output logic mov);
        int u, s;
        u   = int'(ma) - int'(mb) - int'(mbin);
        s   = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        md  = W'(u);
        mbo = (u < 0);
        mov = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
    endfunction

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (prev_done) chk("done_width", done, 0);
        prev_done = done;
        if (rst) busy_cnt = 0;
        else if (busy) busy_cnt++;
        if (done) begin
            done_total++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("diff", diff, e.d);
                chk("bout", bout, e.bo);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                chk("ovf", ovf, e.ov);
`endif
                chk("latency", cyc - e.s_edge, W + 1);
                chk("busy_cycles", busy_cnt, W);
            end
            busy_cnt = 0;
        end
    end

    // Drives a one-cycle start; called just after a rising edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                         input logic [W-1:0] ed, input logic ebo, input logic eov,
                         input bit accepted);
        exp_t e;
        a = ia; b = ib; bin = ibin; start = 1'b1;
        if (accepted) begin
            e.d = ed; e.bo = ebo; e.ov = eov; e.s_edge = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic issue_rand(output bit dummy);
        logic [W-1:0] ra, rb, ed;
        logic         rbin, ebo, eov;
        ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom_range(0, 1));
        model(ra, rb, rbin, ed, ebo, eov);
        issue(ra, rb, rbin, ed, ebo, eov, 1'b1);
        dummy = 1'b1;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_total < target && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (done_total < target) chk("done_timeout", done_total, target);
        @(posedge clk); #1;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  target;
        int  prev;
        bit  dmy;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases with hand-computed results.
        target = 0;
        issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1); target++; wait_done(target);
        issue(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1); target++; wait_done(target);
        issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1); target++; wait_done(target);
        issue(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1); target++; wait_done(target);

        // Start pulse at RUN cycle 3 must be ignored.
        issue(8'h5A, 8'h21, 1'b1, 8'h38, 1'b0, 1'b0, 1'b1); target++;
        repeat (2) begin @(posedge clk); #1; end
        issue(8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        wait_done(target);
        prev = done_total;
        repeat (12) begin @(posedge clk); #1; end
        chk("single_done", done_total, prev);

        // Back-to-back: second start lands in the DONE cycle of the first.
        issue(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b1); target++;
        repeat (W) begin @(posedge clk); #1; end
        issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1); target++;
        wait_done(target);

        // Reset at RUN cycle 4 aborts the operation.
        issue(8'h44, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_bout", bout, 0);
        rst = 1'b0;
        prev = done_total;
        repeat (20) begin @(posedge clk); #1; end
        chk("no_done_after_rst", done_total, prev);

        // Randomized operations, some chained back-to-back.
        for (int i = 0; i < 30; i++) begin
            issue_rand(dmy); target++;
            if ($urandom_range(0, 3) == 0) begin
                repeat (W) begin @(posedge clk); #1; end
                issue_rand(dmy); target++;
            end
            wait_done(target);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (3) begin @(posedge clk); #1; end
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
